axil_ctrl_master: RTL

AXIL_CTRL_MASTER -- requirements
Module: axil_ctrl_master

---
 rtl/axil_ctrl_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axil_ctrl_master.sv
// axil_ctrl_master: single-outstanding command-to-AXI4-Lite master with a per-transaction timeout.
//   aclk/aresetn       : clock, synchronous active-low reset
//   cmd_*              : command in (valid/ready, wr, addr, data, strb)
//   rsp_*              : response out (valid/ready, data, status = {timeout, resp[1:0]})
//   m_axi_aw*/w*/b*    : AXI4-Lite write address, write data and write response channels
//   m_axi_ar*/r*       : AXI4-Lite read address and read data channels
module axil_ctrl_master #(
    parameter int ADDR_BITS      = 64,
    parameter int DATA_BITS      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [DATA_BITS-1:0]   cmd_data,
    input  logic [DATA_BITS/8-1:0] cmd_strb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_BITS-1:0]   rsp_data,
    output logic [2:0]             rsp_status,
    output logic [ADDR_BITS-1:0]   m_axi_awaddr,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [DATA_BITS-1:0]   m_axi_wdata,
    output logic [DATA_BITS/8-1:0] m_axi_wstrb,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [ADDR_BITS-1:0]   m_axi_araddr,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [DATA_BITS-1:0]   m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);
    // Two spare counts so the counter can step past the limit once without wrapping.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
    state_t                 r_state, w_next;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_data, r_rsp_data;
    logic [DATA_BITS/8-1:0] r_strb;
    logic [2:0]             r_rsp_status;
    logic                   r_aw_done, r_w_done;
    logic [CW-1:0]          r_cnt;
    logic                   w_tmo, w_busy;
    assign w_tmo        = r_cnt >= CW'(TIMEOUT_CYCLES - 1);
    assign w_busy       = r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign m_axi_awaddr = r_addr;
    assign m_axi_araddr = r_addr;
    assign m_axi_wdata  = r_data;
    assign m_axi_wstrb  = r_strb;
    assign rsp_data     = r_rsp_data;
    assign rsp_status   = r_rsp_status;
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_next;
    end
    // A handshake that finishes a phase is checked before the timeout so it wins a same-cycle tie.
    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = cmd_wr ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                m_axi_awvalid = !r_aw_done;
                m_axi_wvalid  = !r_w_done;
                if ((r_aw_done || m_axi_awready) && (r_w_done || m_axi_wready)) w_next = WR_RESP;
                else if (w_tmo) w_next = RSP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid || w_tmo) w_next = RSP;
            end
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_next = RD_RESP;
                else if (w_tmo) w_next = RSP;
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid || w_tmo) w_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_addr       <= '0;
            r_data       <= '0;
            r_strb       <= '0;
            r_cnt        <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= 3'b000;
        end else begin
            if (cmd_valid && cmd_ready) begin
                r_addr    <= cmd_addr;
                r_data    <= cmd_data;
                r_strb    <= cmd_strb;
                r_cnt     <= '0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (m_axi_awvalid && m_axi_awready) r_aw_done <= 1'b1;
            if (m_axi_wvalid && m_axi_wready) r_w_done <= 1'b1;
            // Capture the response once, on entry to RSP, so it stays stable while held.
            if (w_busy && w_next == RSP) begin
                r_rsp_data   <= (r_state == RD_RESP && m_axi_rvalid) ? m_axi_rdata : '0;
                r_rsp_status <= (r_state == WR_RESP && m_axi_bvalid) ? {1'b0, m_axi_bresp} :
                                (r_state == RD_RESP && m_axi_rvalid) ? {1'b0, m_axi_rresp} : 3'b110;
            end
        end
    end
endmodule
